// File: rtl/mips_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mips_cpu_pkg
// Shared definitions for the MIPS load/store path:
//   - memory-class opcode constants (OP_LB .. OP_SW)
//   - mem_state_t : state encoding of the load/store bus sequencer
//   - is_load / is_store / is_aligned : opcode classification helpers
// -----------------------------------------------------------------------------
package mips_cpu_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: is_load = 1'b1;
            default:                                            is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    // Byte accesses and the unaligned-word pair (lwl/lwr) accept any offset.
    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: is_aligned = ~off[0];
            OP_LW, OP_SW:         is_aligned = (off == 2'b00);
            default:              is_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_store_lanes.sv
// -----------------------------------------------------------------------------
// mips_cpu_store_lanes
// Combinational byte-lane generator for a single word-wide bus access.
//   opcode     in  6  : memory opcode
//   offset     in  2  : alu_addr[1:0]
//   store_data in  32 : rt value
//   byteenable out 4  : active lanes (all four for loads and sw)
//   writedata  out 32 : store value replicated across lanes
// The narrow store value is replicated onto every lane so the byteenable
// alone selects which lane the memory actually writes.
// -----------------------------------------------------------------------------
module mips_cpu_store_lanes
    import mips_cpu_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata
);

    always_comb begin
        byteenable = 4'b1111;
        writedata  = store_data;
        case (opcode)
            OP_SB: begin
                byteenable = 4'b0001 << offset;
                writedata  = {4{store_data[7:0]}};
            end
            OP_SH: begin
                byteenable = offset[1] ? 4'b1100 : 4'b0011;
                writedata  = {2{store_data[15:0]}};
            end
            default: begin
                byteenable = 4'b1111;
                writedata  = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mips_cpu_mem_access.sv
// -----------------------------------------------------------------------------
// mips_cpu_mem_access
// Load/store bus sequencer between execute and the register-file write port.
// Turns one memory instruction into a single Avalon-style word access and
// stalls the core until it completes. Load data is returned raw; the register
// file extracts lanes and extends using load_vaddr.
//
// Parameter RESET_ADDR_HOLD : 1 -> address returns to 0 when the bus is idle.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   req_valid, opcode, alu_addr, store_data : request from execute
//   stall              : freeze PC/pipeline (combinational in IDLE, 1 in BUS)
//   done               : one-cycle pulse in DONE
//   load_data          : raw read word, load_vaddr : byte offset of access
//   addr_error         : one-cycle pulse after a misaligned request
//   address, read, write, byteenable, writedata : bus request (registered)
//   readdata, waitrequest                       : bus response
//   dbg_state          : current sequencer state
//
// Handshake: a request is accepted on the rising edge where the block is IDLE,
// req_valid=1 and the opcode is an aligned memory op. The bus request is held
// unchanged while waitrequest=1; the transfer completes on the first rising
// edge in BUS where waitrequest=0.
// -----------------------------------------------------------------------------
module mips_cpu_mem_access
    import mips_cpu_pkg::*;
#(
    parameter bit RESET_ADDR_HOLD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] alu_addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  load_vaddr,
    output logic        addr_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output mem_state_t  dbg_state
);

    mem_state_t  r_state;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_address;
    logic [3:0]  r_byteenable;
    logic [31:0] r_writedata;
    logic [1:0]  r_offset;
    logic [31:0] r_load_data;
    logic [1:0]  r_load_vaddr;
    logic        r_done;
    logic        r_addr_error;

    logic        w_is_load;
    logic        w_is_mem;
    logic        w_aligned;
    logic        w_accept;
    logic        w_misaligned;
    logic [3:0]  w_byteenable;
    logic [31:0] w_writedata;

    mips_cpu_store_lanes u_lanes (
        .opcode     (opcode),
        .offset     (alu_addr[1:0]),
        .store_data (store_data),
        .byteenable (w_byteenable),
        .writedata  (w_writedata)
    );

    assign w_is_load    = is_load(opcode);
    assign w_is_mem     = w_is_load | is_store(opcode);
    assign w_aligned    = is_aligned(opcode, alu_addr[1:0]);
    assign w_accept     = (r_state == ST_IDLE) & req_valid & w_is_mem & w_aligned;
    assign w_misaligned = (r_state == ST_IDLE) & req_valid & w_is_mem & ~w_aligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= 32'd0;
            r_byteenable <= 4'd0;
            r_writedata  <= 32'd0;
            r_offset     <= 2'd0;
            r_load_data  <= 32'd0;
            r_load_vaddr <= 2'd0;
            r_done       <= 1'b0;
            r_addr_error <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_addr_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_BUS;
                        r_address    <= {alu_addr[31:2], 2'b00};
                        r_read       <= w_is_load;
                        r_write      <= ~w_is_load;
                        r_byteenable <= w_byteenable;
                        r_writedata  <= w_writedata;
                        r_offset     <= alu_addr[1:0];
                    end else if (w_misaligned) begin
                        r_addr_error <= 1'b1;
                    end
                end
                ST_BUS: begin
                    if (!waitrequest) begin
                        r_state      <= ST_DONE;
                        r_done       <= 1'b1;
                        r_read       <= 1'b0;
                        r_write      <= 1'b0;
                        r_byteenable <= 4'd0;
                        r_load_vaddr <= r_offset;
                        if (r_read) begin
                            r_load_data <= readdata;
                        end
                        if (RESET_ADDR_HOLD) begin
                            r_address <= 32'd0;
                        end
                    end
                end
                ST_DONE: begin
                    // Any request presented here is the same instruction the
                    // pipeline is about to advance past; it is not accepted.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // stall must rise in the request cycle itself, so it cannot be registered.
    assign stall      = w_accept | (r_state == ST_BUS);
    assign done       = r_done;
    assign addr_error = r_addr_error;
    assign load_data  = r_load_data;
    assign load_vaddr = r_load_vaddr;
    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_write;
    assign byteenable = r_byteenable;
    assign writedata  = r_writedata;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mips_cpu_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_mem_access
// Self-checking bench for mips_cpu_mem_access: a bus responder with
// programmable wait states, a monitor that pops expected bus/done records,
// and directed plus random request sequences.
// -----------------------------------------------------------------------------
module tb_mips_cpu_mem_access;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LWL = 6'b100010;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LWR = 6'b100110;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;
    localparam int BUS_W  = 69;   // {is_write, address, byteenable, writedata}
    localparam int DONE_W = 34;   // {load_data, load_vaddr}

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [31:0] alu_addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] readdata = 32'd0;
    logic        waitrequest = 1'b0;
    logic        stall, done, addr_error, read, write;
    logic [31:0] load_data, address, writedata;
    logic [1:0]  load_vaddr;
    logic [3:0]  byteenable;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    mips_cpu_mem_access #(.RESET_ADDR_HOLD(1'b0)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .opcode      (opcode),
        .alu_addr    (alu_addr),
        .store_data  (store_data),
        .stall       (stall),
        .done        (done),
        .load_data   (load_data),
        .load_vaddr  (load_vaddr),
        .addr_error  (addr_error),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [BUS_W-1:0]  exp_bus_q[$];
    logic [DONE_W-1:0] exp_done_q[$];
    logic [31:0]       model_ld = 32'd0;
    logic [BUS_W-1:0]  cur_bus = '0;
    logic [DONE_W-1:0] cur_done;
    logic              prev_strobe = 1'b0;
    int                cfg_wait = 0;
    logic [31:0]       cfg_rdata = 32'd0;
    int                wait_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference lane model: returns {byteenable, writedata}.
    function automatic logic [35:0] model_lanes(input logic [5:0] op, input logic [1:0] o,
                                                input logic [31:0] sd);
        logic [3:0]  be;
        logic [31:0] wd;
        case (op)
            SB: begin
                case (o)
                    2'd0:    be = 4'b0001;
                    2'd1:    be = 4'b0010;
                    2'd2:    be = 4'b0100;
                    default: be = 4'b1000;
                endcase
                wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            end
            SH: begin
                be = (o >= 2'd2) ? 4'b1100 : 4'b0011;
                wd = {sd[15:0], sd[15:0]};
            end
            SW:      begin be = 4'b1111; wd = sd;    end
            default: begin be = 4'b1111; wd = 32'd0; end
        endcase
        return {be, wd};
    endfunction

    task automatic push_access(input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] sd, input logic [31:0] rdata,
                               input bit with_done);
        logic        wr;
        logic [35:0] lanes;
        wr    = (op == SB) || (op == SH) || (op == SW);
        lanes = model_lanes(op, addr[1:0], sd);
        exp_bus_q.push_back({wr, addr[31:2], 2'b00, lanes});
        if (with_done) begin
            if (!wr) model_ld = rdata;
            exp_done_q.push_back({model_ld, addr[1:0]});
        end
    endtask

    // ---------------- bus responder ----------------
    // Inserts cfg_wait wait cycles per access; readdata is junk while waiting.
    always @(negedge clk) begin
        if ((read || write) && wait_cnt < cfg_wait) begin
            waitrequest = 1'b1;
            wait_cnt++;
            readdata = $urandom;
        end else begin
            waitrequest = 1'b0;
            readdata = cfg_rdata;
            if (!(read || write)) wait_cnt = 0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (read || write) begin
                if (!prev_strobe) begin
                    if (exp_bus_q.size() == 0) begin
                        check_eq("unexpected_bus", 1, 0);
                        cur_bus = '0;
                    end else begin
                        cur_bus = exp_bus_q.pop_front();
                    end
                end
                check_eq("bus_write", write, cur_bus[68]);
                check_eq("bus_read", read, !cur_bus[68]);
                check_eq("bus_addr", address, cur_bus[67:36]);
                check_eq("bus_be", byteenable, cur_bus[35:32]);
                if (cur_bus[68]) check_eq("bus_wdata", writedata, cur_bus[31:0]);
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    check_eq("unexpected_done", 1, 0);
                end else begin
                    cur_done = exp_done_q.pop_front();
                    check_eq("load_data", load_data, cur_done[33:2]);
                    check_eq("load_vaddr", load_vaddr, cur_done[1:0]);
                end
            end
        end
        prev_strobe = read || write;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [5:0] op,
                             input logic [31:0] addr, input logic [31:0] sd);
        req_valid  = v;
        opcode     = op;
        alu_addr   = addr;
        store_data = sd;
    endtask

    task automatic run_single(input logic [5:0] op, input logic [31:0] addr,
                              input logic [31:0] sd, input int nwait, input logic [31:0] rdata);
        int stall_n;
        int strb_n;
        int done_at;
        cfg_wait  = nwait;
        cfg_rdata = rdata;
        push_access(op, addr, sd, rdata, 1'b1);
        tick();
        drive_req(1'b1, op, addr, sd);
        stall_n = 0;
        strb_n  = 0;
        done_at = -1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (stall) stall_n++;
            if (read || write) strb_n++;
            if (done) begin
                done_at = c;
                break;
            end
            tick();
            req_valid = 1'b0;
        end
        check_eq("stall_cycles", stall_n, nwait + 2);
        check_eq("strobe_cycles", strb_n, nwait + 1);
        check_eq("done_cycle", done_at, nwait + 2);
        tick();
        #1;
        check_eq("done_one_pulse", done, 1'b0);
        check_eq("idle_stall", stall, 1'b0);
    endtask

    // A request that must not start a bus cycle; err_exp says whether addr_error fires.
    task automatic run_rejected(input logic [5:0] op, input logic [31:0] addr, input logic err_exp);
        tick();
        drive_req(1'b1, op, addr, 32'h5555_AAAA);
        #1;
        check_eq("rej_stall", stall, 1'b0);
        tick();
        req_valid = 1'b0;
        #1;
        check_eq("rej_addr_error", addr_error, err_exp);
        check_eq("rej_read", read, 1'b0);
        check_eq("rej_write", write, 1'b0);
        check_eq("rej_state", dbg_state, 2'd0);
        check_eq("rej_stall2", stall, 1'b0);
        tick();
        #1;
        check_eq("rej_addr_error_clear", addr_error, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0]  ops[10];
        logic [5:0]  op;
        logic [31:0] a;
        int          rd_at, wr_at, d1, d2;

        ops = '{LB, LH, LWL, LW, LBU, LHU, LWR, SB, SH, SW};
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check_eq("rst_read", read, 1'b0);
        check_eq("rst_write", write, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_addr_error", addr_error, 1'b0);
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_be", byteenable, 4'd0);
        check_eq("rst_address", address, 32'd0);
        check_eq("rst_wdata", writedata, 32'd0);
        check_eq("rst_load_data", load_data, 32'd0);
        check_eq("rst_load_vaddr", load_vaddr, 2'd0);
        check_eq("rst_state", dbg_state, 2'd0);

        // Directed accesses
        run_single(LW,  32'h1000_0004, 32'h0,          0, 32'hDEAD_BEEF);
        run_single(SB,  32'h0000_0013, 32'h0000_00A5,  0, 32'h0BAD_0BAD);
        run_single(SH,  32'h0000_0022, 32'h1234_ABCD,  3, 32'h0);
        run_single(LBU, 32'h0000_0103, 32'h0,          2, 32'h8070_6050);
        run_single(LWL, 32'h0000_0201, 32'h0,          0, 32'hA1B2_C3D4);
        run_single(LWR, 32'h0000_0302, 32'h0,          1, 32'h0F1E_2D3C);
        run_single(LH,  32'h0000_0402, 32'h0,          0, 32'h7777_8888);
        run_single(SW,  32'h0000_0500, 32'hCAFE_BABE,  1, 32'h0);
        run_single(SH,  32'h0000_0600, 32'h0000_5A5A,  0, 32'h0);

        // Random aligned accesses
        for (int i = 0; i < 8; i++) begin
            op = ops[$urandom_range(0, 9)];
            a  = $urandom;
            if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
            if (op == LW || op == SW) a[1:0] = 2'b00;
            run_single(op, a, $urandom, $urandom_range(0, 3), $urandom);
        end

        // Misaligned and non-memory requests
        run_rejected(LH,  32'h0000_0001, 1'b1);
        run_rejected(SW,  32'h0000_0042, 1'b1);
        run_rejected(LHU, 32'h0000_0083, 1'b1);
        run_rejected(6'b000000, 32'h0000_0000, 1'b0);
        run_rejected(6'b101010, 32'h0000_0010, 1'b0);

        // Reset while the bus is stalled: transfer abandoned, no done
        cfg_wait = 100;
        push_access(SW, 32'h0000_0040, 32'h1357_9BDF, 32'h0, 1'b0);
        tick();
        drive_req(1'b1, SW, 32'h0000_0040, 32'h1357_9BDF);
        tick();
        req_valid = 1'b0;
        #1;
        check_eq("rstbus_write_on", write, 1'b1);
        tick();
        #1;
        check_eq("rstbus_write_held", write, 1'b1);
        check_eq("rstbus_stall_held", stall, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("rstbus_read", read, 1'b0);
        check_eq("rstbus_write", write, 1'b0);
        check_eq("rstbus_done", done, 1'b0);
        check_eq("rstbus_state", dbg_state, 2'd0);
        check_eq("rstbus_stall", stall, 1'b0);
        check_eq("rstbus_load_data", load_data, 32'd0);
        model_ld = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check_eq("rstbus_no_done", done, 1'b0);
        end
        cfg_wait = 0;

        // Back-to-back lb then sw with req_valid held
        cfg_rdata = 32'h1122_3344;
        push_access(LB, 32'h2000_0002, 32'h0, 32'h1122_3344, 1'b1);
        push_access(SW, 32'h2000_0008, 32'hCAFE_F00D, 32'h0, 1'b1);
        rd_at = -1; wr_at = -1; d1 = -1; d2 = -1;
        tick();
        drive_req(1'b1, LB, 32'h2000_0002, 32'h0);
        for (int c = 0; c < 30; c++) begin
            #1;
            if (read && rd_at < 0) rd_at = c;
            if (write && wr_at < 0) wr_at = c;
            if (done) begin
                if (d1 < 0) begin
                    d1 = c;
                    check_eq("b2b_done_stall", stall, 1'b0);
                end else begin
                    d2 = c;
                    break;
                end
            end
            tick();
            if (d1 >= 0) drive_req(1'b1, SW, 32'h2000_0008, 32'hCAFE_F00D);
        end
        tick();
        req_valid = 1'b0;
        #1;
        check_eq("b2b_read_cycle", rd_at, 1);
        check_eq("b2b_done1_cycle", d1, 2);
        check_eq("b2b_write_cycle", wr_at, 4);
        check_eq("b2b_done2_cycle", d2, 5);
        check_eq("b2b_no_extra_done", done, 1'b0);

        repeat (2) tick();
        check_eq("bus_queue_empty", exp_bus_q.size(), 0);
        check_eq("done_queue_empty", exp_done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
